// File: rtl/str_wr.sv
// CPU-to-stream bridge: AXI4-Lite loaded words are committed as one wide AXIS beat,
// with sent/drop accounting and downstream FIFO occupancy readback.
module str_wr #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
   parameter int unsigned N_PKT              = 3
) (
   input  logic                              s_axi_aclk,
   input  logic                              s_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                        s_axi_awprot,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                        s_axi_arprot,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic [32*N_PKT-1:0]               m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   input  logic [31:0]                       write_data_count,
   input  logic [31:0]                       read_data_count,
   output logic                              busy
);

   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned IW = AW - 2;
   localparam int unsigned TW = 32 * N_PKT;

   localparam logic [IW-1:0] IDX_CTRL   = IW'(16);
   localparam logic [IW-1:0] IDX_STATUS = IW'(17);
   localparam logic [IW-1:0] IDX_SENT   = IW'(18);
   localparam logic [IW-1:0] IDX_DROP   = IW'(19);
   localparam logic [IW-1:0] IDX_WDC    = IW'(20);
   localparam logic [IW-1:0] IDX_RDC    = IW'(21);
   localparam logic [IW-1:0] IDX_CLEAR  = IW'(22);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_PKT - 1);

   logic          awready_q, awready_d;
   logic          bvalid_q,  bvalid_d;
   logic          arready_q, arready_d;
   logic          rvalid_q,  rvalid_d;
   logic [DW-1:0] rdata_q,   rdata_d;
   logic [DW-1:0] data_q [N_PKT];
   logic [DW-1:0] data_d [N_PKT];
   logic          auto_q,    auto_d;
   logic          tvalid_q,  tvalid_d;
   logic [TW-1:0] tdata_q,   tdata_d;
   logic [31:0]   sent_q,    sent_d;
   logic [31:0]   dcnt_q,    dcnt_d;
   logic          drop_q,    drop_d;

   logic          wr_hs_c, rd_hs_c, ctrl_wr_c, send_c, clear_c, commit_c;
   logic          xfer_c, accept_c, reject_c;
   logic [IW-1:0] widx_c, ridx_c;
   logic [DW-1:0] rmux_c;
   logic [TW-1:0] snap_c;

   assign widx_c = s_axi_awaddr[AW-1:2];
   assign ridx_c = s_axi_araddr[AW-1:2];

   // Next-state logic for the AXI-Lite slave, register file and stream output.
   always_comb begin
      awready_d = ~awready_q & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
      arready_d = ~arready_q & s_axi_arvalid & ~rvalid_q;
      wr_hs_c   = awready_q & s_axi_awvalid & s_axi_wvalid;
      rd_hs_c   = arready_q & s_axi_arvalid;
      bvalid_d  = wr_hs_c ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
      rvalid_d  = rd_hs_c ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);

      for (int i = 0; i < int'(N_PKT); i++) begin
         data_d[i] = data_q[i];
         if (wr_hs_c && widx_c == IW'(i)) begin
            for (int b = 0; b < int'(SW); b++) begin
               if (s_axi_wstrb[b]) data_d[i][8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
         end
      end
      snap_c = '0;
      for (int i = 0; i < int'(N_PKT); i++) snap_c[32*i +: 32] = data_d[i];

      ctrl_wr_c = wr_hs_c & (widx_c == IDX_CTRL) & s_axi_wstrb[0];
      send_c    = ctrl_wr_c & s_axi_wdata[0];
      clear_c   = wr_hs_c & (widx_c == IDX_CLEAR) & s_axi_wstrb[0] & s_axi_wdata[0];
      auto_d    = ctrl_wr_c ? s_axi_wdata[1] : auto_q;
      commit_c  = send_c | (wr_hs_c & (widx_c == IDX_LAST) & auto_q);

      // A beat completing in the commit cycle frees the slot for the new one.
      xfer_c   = tvalid_q & m_axis_tready;
      accept_c = commit_c & (~tvalid_q | m_axis_tready);
      reject_c = commit_c & tvalid_q & ~m_axis_tready;
      tvalid_d = accept_c ? 1'b1 : (xfer_c ? 1'b0 : tvalid_q);
      tdata_d  = accept_c ? snap_c : tdata_q;

      sent_d = clear_c ? 32'd0 : (xfer_c ? sent_q + 32'd1 : sent_q);
      dcnt_d = clear_c ? 32'd0 :
               ((reject_c && dcnt_q != 32'hFFFF_FFFF) ? dcnt_q + 32'd1 : dcnt_q);
      drop_d = clear_c ? 1'b0 : (drop_q | reject_c);

      rmux_c = '0;
      for (int i = 0; i < int'(N_PKT); i++) begin
         if (ridx_c == IW'(i)) rmux_c = data_q[i];
      end
      case (ridx_c)
         IDX_CTRL:   rmux_c = DW'({auto_q, 1'b0});
         IDX_STATUS: rmux_c = DW'({drop_q, tvalid_q});
         IDX_SENT:   rmux_c = sent_q;
         IDX_DROP:   rmux_c = dcnt_q;
         IDX_WDC:    rmux_c = write_data_count;
         IDX_RDC:    rmux_c = read_data_count;
         default:    ;
      endcase
      rdata_d = rd_hs_c ? rmux_c : rdata_q;
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         for (int i = 0; i < int'(N_PKT); i++) data_q[i] <= '0;
         auto_q    <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         sent_q    <= '0;
         dcnt_q    <= '0;
         drop_q    <= 1'b0;
      end else begin
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         data_q    <= data_d;
         auto_q    <= auto_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         sent_q    <= sent_d;
         dcnt_q    <= dcnt_d;
         drop_q    <= drop_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign busy          = tvalid_q;

   logic unused_ok_c;
   assign unused_ok_c = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_str_wr.sv
// Randomized bench for str_wr: a per-cycle rule model of the register map and
// stream slot is compared against the DUT, plus directed register readbacks.
module tb_str_wr;

   localparam int unsigned N  = 3;
   localparam int unsigned TW = 32 * N;

   logic          clk = 1'b0;
   logic          areset = 1'b1;
   logic [7:0]    awaddr = '0;
   logic [2:0]    awprot = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready = 1'b1;
   logic [7:0]    araddr = '0;
   logic [2:0]    arprot = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready = 1'b1;
   logic [TW-1:0] tdata;
   logic          tvalid;
   logic          tready = 1'b1;
   logic [31:0]   wdc = 32'h1234;
   logic [31:0]   rdc = 32'h5678;
   logic          busy;

   str_wr #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .N_PKT(N)) dut (
      .s_axi_aclk(clk), .s_axi_areset(areset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
      .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .write_data_count(wdc), .read_data_count(rdc),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit rnd_en   = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model state, following the register-map and stream rules.
   logic [31:0]   m_data [N];
   bit            m_auto, m_busy, m_drop;
   logic [31:0]   m_sent, m_dcnt;
   logic [TW-1:0] m_beat;
   logic [TW-1:0] last_beat;

   initial begin
      for (int i = 0; i < int'(N); i++) m_data[i] = '0;
      {m_auto, m_busy, m_drop} = '0;
      m_sent = '0; m_dcnt = '0; m_beat = '0; last_beat = '0;
      forever begin
         @(negedge clk);
         if (!areset) begin
            chk("tvalid", tvalid, m_busy);
            chk("busy", busy, m_busy);
            if (m_busy) chk("tdata", tdata, m_beat);
         end
         if (tvalid && tready) last_beat = tdata;
         if (areset) begin
            for (int i = 0; i < int'(N); i++) m_data[i] = '0;
            {m_auto, m_busy, m_drop} = '0;
            m_sent = '0; m_dcnt = '0;
         end else begin
            bit snd, clr, autoc, xfer;
            int idx;
            snd = 0; clr = 0; autoc = 0;
            idx = int'(awaddr[7:2]);
            if (awready && awvalid && wvalid) begin
               if (idx < int'(N)) begin
                  for (int b = 0; b < 4; b++)
                     if (wstrb[b]) m_data[idx][8*b +: 8] = wdata[8*b +: 8];
                  if (idx == int'(N) - 1 && m_auto) autoc = 1;
               end
               if (idx == 16 && wstrb[0]) begin
                  snd = wdata[0];
                  m_auto = wdata[1];
               end
               if (idx == 22 && wstrb[0] && wdata[0]) clr = 1;
            end
            xfer = m_busy && tready;
            if (xfer) m_sent = m_sent + 1;
            if (snd || autoc) begin
               if (!m_busy || tready) begin
                  m_busy = 1;
                  for (int i = 0; i < int'(N); i++) m_beat[32*i +: 32] = m_data[i];
               end else begin
                  m_drop = 1;
                  if (m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 1;
               end
            end else if (xfer) m_busy = 0;
            if (clr) begin
               m_sent = '0; m_dcnt = '0; m_drop = 0;
            end
         end
      end
   end

   function automatic logic [31:0] exp_rd(input logic [7:0] a);
      int idx;
      idx = int'(a[7:2]);
      if (idx < int'(N)) return m_data[idx];
      case (idx)
         16: return {30'd0, m_auto, 1'b0};
         17: return {30'd0, m_drop, m_busy};
         18: return m_sent;
         19: return m_dcnt;
         20: return wdc;
         21: return rdc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk); #1;
      if (rnd_en) tready = 1'($urandom_range(0, 1));
   endtask

   task automatic axi_wr(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s = 4'hF, input bit pulse_rdy = 0);
      bit got;
      step();
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      step();
      if (pulse_rdy) tready = 1;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (awready) begin got = 1; break; end
      end
      if (!got) chk("awready_timeout", 0, 1);
      step();
      awvalid = 0; wvalid = 0;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         if (bvalid) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) chk("bvalid_timeout", 0, 1);
      else chk("bresp", bresp, 2'b00);
      step();
   endtask

   task automatic axi_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      bit got;
      step();
      araddr = a; arvalid = 1;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (arready) begin got = 1; break; end
      end
      if (!got) chk("arready_timeout", 0, 1);
      step();
      arvalid = 0;
      got = 0; d = '0; r = '0;
      for (int k = 0; k < 20; k++) begin
         if (rvalid) begin got = 1; d = rdata; r = rresp; break; end
         @(negedge clk);
      end
      if (!got) chk("rvalid_timeout", 0, 1);
      step();
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a);
      logic [31:0] d;
      logic [1:0]  r;
      axi_rd(a, d, r);
      chk(tag, d, exp_rd(a));
   endtask

   task automatic rd_const(input string tag, input logic [7:0] a, input logic [31:0] e);
      logic [31:0] d;
      logic [1:0]  r;
      axi_rd(a, d, r);
      chk(tag, d, e);
      chk({tag, "_resp"}, r, 2'b00);
   endtask

   initial begin
      int aw_p, ar_p;
      repeat (3) @(posedge clk);
      #1 areset = 0;

      // Reset state and full register map readback.
      rd_const("rst_data0", 8'h00, 32'h0);
      rd_const("rst_data1", 8'h04, 32'h0);
      rd_const("rst_data2", 8'h08, 32'h0);
      rd_const("rst_ctrl", 8'h40, 32'h0);
      rd_const("rst_status", 8'h44, 32'h0);
      rd_const("rst_sent", 8'h48, 32'h0);
      rd_const("rst_drop", 8'h4C, 32'h0);
      rd_const("rst_wdc", 8'h50, 32'h1234);
      rd_const("rst_rdc", 8'h54, 32'h5678);
      rd_const("rst_clear", 8'h58, 32'h0);
      rd_const("unmapped", 8'h7C, 32'h0);

      // Basic commit with ready downstream.
      axi_wr(8'h00, 32'h1111_1111);
      axi_wr(8'h04, 32'h2222_2222);
      axi_wr(8'h08, 32'h3333_3333);
      axi_wr(8'h40, 32'h1);
      repeat (2) step();
      chk("beat1", last_beat, 96'h3333_3333_2222_2222_1111_1111);
      rd_const("sent1", 8'h48, 32'd1);

      // Held beat: second commit is dropped, held data unaffected.
      axi_wr(8'h58, 32'h1);
      tready = 0;
      axi_wr(8'h40, 32'h1);
      axi_wr(8'h00, 32'hAAAA_AAAA);
      axi_wr(8'h40, 32'h1);
      chk("held_tdata", tdata, 96'h3333_3333_2222_2222_1111_1111);
      rd_const("status_drop", 8'h44, 32'h3);
      rd_const("dropcnt1", 8'h4C, 32'd1);
      tready = 1;
      repeat (2) step();
      rd_const("sent_after_release", 8'h48, 32'd1);

      // AUTO mode: writing the last word commits.
      axi_wr(8'h58, 32'h1);
      axi_wr(8'h40, 32'h2);
      axi_wr(8'h00, 32'h4444_4444);
      axi_wr(8'h04, 32'h5555_5555);
      axi_wr(8'h08, 32'h6666_6666);
      repeat (2) step();
      chk("auto_beat", last_beat, 96'h6666_6666_5555_5555_4444_4444);
      rd_const("auto_sent", 8'h48, 32'd1);
      rd_chk("auto_ctrl", 8'h40);

      // Commit in the same cycle the held beat completes: back-to-back.
      axi_wr(8'h40, 32'h0);
      axi_wr(8'h58, 32'h1);
      tready = 0;
      axi_wr(8'h40, 32'h1);
      axi_wr(8'h40, 32'h1, 4'hF, 1);
      repeat (3) step();
      rd_const("b2b_drop", 8'h4C, 32'd0);
      rd_const("b2b_sent", 8'h48, 32'd2);

      // Byte strobes on DATA.
      axi_wr(8'h04, 32'h0);
      axi_wr(8'h04, 32'hDEAD_BEEF, 4'b0010);
      rd_const("strobe", 8'h04, 32'h0000_BE00);

      // Response back-pressure: no new handshakes while responses are pending.
      step();
      bready = 0; rready = 0;
      awaddr = 8'h00; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 8'h48; arvalid = 1;
      aw_p = 0; ar_p = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (awready) aw_p++;
         if (arready) ar_p++;
      end
      chk("aw_pulses", 32'(aw_p), 32'd1);
      chk("ar_pulses", 32'(ar_p), 32'd1);
      chk("bvalid_held", bvalid, 1'b1);
      chk("rvalid_held", rvalid, 1'b1);
      step();
      awvalid = 0; wvalid = 0; arvalid = 0;
      step();
      bready = 1; rready = 1;
      repeat (2) step();
      chk("bvalid_clr", bvalid, 1'b0);
      chk("rvalid_clr", rvalid, 1'b0);
      rd_chk("bp_data0", 8'h00);

      // Randomized traffic with random downstream back-pressure.
      rnd_en = 1;
      for (int n = 0; n < 250; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 4)
            axi_wr(8'(4 * $urandom_range(0, N - 1)), $urandom, 4'($urandom_range(0, 15)));
         else if (op <= 6)
            axi_wr(8'h40, 32'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? 4'hE : 4'hF);
         else if (op == 7)
            axi_wr(($urandom_range(0, 1) == 0) ? 8'h58 : 8'h60, $urandom);
         else
            rd_chk("rnd_data", 8'(4 * $urandom_range(0, N - 1)));
      end
      rnd_en = 0;
      tready = 1;
      repeat (3) step();
      rd_chk("rnd_sent", 8'h48);
      rd_chk("rnd_drop", 8'h4C);
      rd_chk("rnd_status", 8'h44);
      rd_chk("rnd_ctrl", 8'h40);

      // Reset while a beat is held: abandoned, not counted.
      axi_wr(8'h40, 32'h0);
      axi_wr(8'h58, 32'h1);
      tready = 0;
      axi_wr(8'h40, 32'h1);
      step();
      areset = 1;
      step();
      areset = 0;
      chk("rst_tvalid", tvalid, 1'b0);
      tready = 1;
      repeat (2) step();
      rd_const("rst_sent2", 8'h48, 32'd0);
      rd_const("rst_status2", 8'h44, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/str_wr.md
Name: str_wr

Overview:
- CPU-to-stream bridge: software loads N_PKT 32-bit words through AXI4-Lite registers, then commits them.
- On commit the block emits them as one wide AXIS beat on a master port, normally feeding a FIFO toward the PL datapath.
- Transmit counterpart of the stream-read register block.
- Reports sent/dropped counts and downstream FIFO occupancy.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 8, AXI-Lite address width; minimum 7.
- N_PKT, 3, 32-bit words per AXIS beat; legal range 1..16.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awprot/awvalid/awready, s_axi_wdata/wstrb/wvalid/wready, s_axi_bresp/bvalid/bready, s_axi_araddr/arprot/arvalid/arready, s_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite slave; prot ignored.
- m_axis_tdata  out  32*N_PKT  beat; word i at bits [32i+31:32i].
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- write_data_count  in  32  downstream FIFO write count, readable.
- read_data_count  in  32  downstream FIFO read count, readable.
- busy  out  1  equals m_axis_tvalid.

Behaviour:
- Reset: all AXI ready/valid outputs 0; rdata 0; resp 00; m_axis_tvalid 0; tdata 0; DATA regs 0; CTRL 0; counters 0; DROP flag 0.
- Address map (byte addresses, low 2 bits ignored):
  - 0x00+4i: DATAi, i<N_PKT, RW.
  - 0x40 CTRL, RW: bit0 SEND, write-1 self-clearing, reads 0; bit1 AUTO.
  - 0x44 STATUS, RO: bit0 busy; bit1 DROP sticky.
  - 0x48 SENT_CNT, RO.
  - 0x4C DROP_CNT, RO.
  - 0x50 write_data_count; 0x54 read_data_count.
  - 0x58 CLEAR, WO: bit0 clears DROP, DROP_CNT and SENT_CNT.
- Unmapped addresses: writes ignored, reads return 0, resp always OKAY.
- Write channel:
  - awready and wready pulse together for one cycle when awvalid & wvalid & ~bvalid.
  - Register update occurs on that cycle.
  - bvalid rises the next cycle and holds until bready.
  - wstrb applied per byte on DATA regs; CTRL/CLEAR act only if wstrb[0].
- Read channel:
  - arready pulses one cycle when arvalid & ~rvalid.
  - rdata registered on that cycle; rvalid the next cycle, held until rready.
  - Read and write may proceed concurrently.
- Commit event:
  - Triggered by a SEND write, or by a write to DATA(N_PKT-1) while AUTO=1.
  - If a SEND write also sets AUTO, both take effect and a single commit occurs.
- On commit with m_axis_tvalid=0:
  - The next cycle, tdata = snapshot of DATA regs including the same-cycle write, and tvalid=1.
  - DATA regs stay writable without affecting the held beat.
- On commit with m_axis_tvalid=1:
  - Commit is dropped; DROP set; DROP_CNT++ (saturates at 0xFFFFFFFF).
  - Exception: if tvalid & tready completes in the same cycle, the commit is accepted and tvalid stays 1 with the new data.
- Handshake:
  - tvalid & tready completes the beat; SENT_CNT++ (wraps).
  - tvalid deasserts next cycle unless a new commit is accepted.
  - tdata stable while tvalid=1 and tready=0.
- CLEAR coincident with a transfer or drop: CLEAR wins; the counter reads 0.
- Reset mid-transfer: beat abandoned, tvalid=0 next cycle, no count.

Test Plan:
- Reset, then read every address:
  - All regs read 0; 0x50/0x54 mirror the inputs (e.g. 0x1234).
  - 0x7C returns 0 with OKAY.
- Write DATA0..2 = 0x11111111, 0x22222222, 0x33333333, SEND, tready=1:
  - One beat with tdata = 0x333333332222222211111111.
  - tvalid high exactly 1 cycle; SENT_CNT=1.
- Hold tready=0, SEND, rewrite DATA0=0xAAAAAAAA, SEND again:
  - tdata unchanged, second commit dropped, STATUS=0x3, DROP_CNT=1.
  - Release tready: one beat, SENT_CNT=1.
- AUTO=1, write DATA0..2:
  - Beat emitted one cycle after the DATA2 write; no SEND needed.
- tready=1, issue SEND in the same cycle the previous beat completes:
  - New beat follows back-to-back, DROP_CNT=0, SENT_CNT=2.
- wstrb=0b0010 write 0xDEADBEEF to DATA1 (previously 0), then read DATA1:
  - Read returns 0x0000BE00.
- Hold bready=0 and rready=0 for 5 cycles:
  - bvalid/rvalid held; no further awready/arready pulses.
